// File: rtl/full_st0_ctrl_seq_pkg.sv
// Shared types and default dimensions for the stage-0 sequencer of the
// fully-connected layer. The output controller uses the same constants.
package full_st0_ctrl_seq_pkg;

  localparam int DEF_IN_LEN   = 6;
  localparam int DEF_NUM_ROWS = 12;
  localparam int DEF_PIPE_LAT = 5;
  localparam int DEF_PRE_LAT  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/full_st0_vld_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
// any_set reports whether any stage still holds a non-zero value.
module full_st0_vld_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_set
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  // Next contents: new value enters stage 0, every other stage takes its predecessor.
  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Stage registers; reset empties the whole line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  // Occupancy flag, used to decide when in-flight results have left.
  always_comb begin
    any_set = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_set = any_set | (|sr_q[i]);
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/full_st0_ctrl_seq.sv
// Stage-0 sequencer: counts input-vector writes, then walks every tap row
// and data address, producing read strobes and pipeline-aligned markers.
// Optional feature: define FULL_ST0_SEQ_STALL_EN to let stage_0_data_out_rdy
// hold off the start of a new row.
module full_st0_ctrl_seq
  import full_st0_ctrl_seq_pkg::*;
#(
  parameter int IN_LEN   = DEF_IN_LEN,
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int PRE_LAT  = DEF_PRE_LAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_valid,
  output logic [5:0] data_write_addr,
  output logic [5:0] data_read_addr,
  output logic [3:0] tap_address,
  output logic       active_normal,
  output logic       active_start_d,
  output logic       active_pre,
  output logic       active,
  output logic [3:0] bias_wr_address,
  output logic       read_finish,
  input  logic       stage_0_data_out_rdy,
  output logic       busy,
  output logic       overrun
);

  localparam int BEAT_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;

  seq_state_e        state_q, state_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [3:0]        row_q, row_d;
  logic              overrun_q, overrun_d;
  logic              issue;
  logic              hold;
  logic              start_mark, last_mark, finish_mark;
  logic              pipe_any;
  logic              unused_start_any, unused_pre_any, unused_fin_any, unused_bias_any;

`ifdef FULL_ST0_SEQ_STALL_EN
  assign hold = (beat_q == '0) && !stage_0_data_out_rdy;
`else
  logic unused_rdy;
  assign unused_rdy = stage_0_data_out_rdy;
  assign hold = 1'b0;
`endif

  // Frame sequencing: write counting in LOAD, row/beat walk in RUN, then drain.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    beat_d    = beat_q;
    row_d     = row_q;
    overrun_d = overrun_q;
    issue     = 1'b0;
    if (data_valid && (state_q != LOAD)) begin
      overrun_d = 1'b1;
    end
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (data_valid) begin
          if (wcnt_q == 6'(IN_LEN - 1)) begin
            wcnt_d  = '0;
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + 6'd1;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          issue = 1'b1;
          if (beat_q == BEAT_W'(IN_LEN - 1)) begin
            beat_d = '0;
            if (row_q == 4'(NUM_ROWS - 1)) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + 4'd1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!pipe_any) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      beat_q    <= '0;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      beat_q    <= beat_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end

  assign start_mark  = issue && (beat_q == '0);
  assign last_mark   = issue && (beat_q == BEAT_W'(IN_LEN - 1));
  assign finish_mark = last_mark && (row_q == 4'(NUM_ROWS - 1));

  assign active_normal   = issue;
  assign data_write_addr = wcnt_q;
  assign data_read_addr  = 6'(beat_q);
  assign tap_address     = row_q;
  assign busy            = (state_q == RUN) || (state_q == DRAIN) || (state_q == DONE);
  assign overrun         = overrun_q;

  full_st0_vld_delay #(.DEPTH(1), .WIDTH(1)) u_start_dly (
    .clk(clk), .rst_n(reset), .din(start_mark), .dout(active_start_d), .any_set(unused_start_any)
  );

  full_st0_vld_delay #(.DEPTH(PRE_LAT), .WIDTH(1)) u_pre_dly (
    .clk(clk), .rst_n(reset), .din(last_mark), .dout(active_pre), .any_set(unused_pre_any)
  );

  full_st0_vld_delay #(.DEPTH(PIPE_LAT), .WIDTH(1)) u_act_dly (
    .clk(clk), .rst_n(reset), .din(last_mark), .dout(active), .any_set(pipe_any)
  );

  full_st0_vld_delay #(.DEPTH(PIPE_LAT), .WIDTH(1)) u_fin_dly (
    .clk(clk), .rst_n(reset), .din(finish_mark), .dout(read_finish), .any_set(unused_fin_any)
  );

  full_st0_vld_delay #(.DEPTH(PIPE_LAT - 1), .WIDTH(4)) u_bias_dly (
    .clk(clk), .rst_n(reset), .din(row_q), .dout(bias_wr_address), .any_set(unused_bias_any)
  );

endmodule

// File: tb/tb_full_st0_ctrl_seq.sv
// Scoreboard bench for full_st0_ctrl_seq: stimulus pushes the expected frame
// (row/beat walk) into a queue, a negedge monitor pops and compares.
module tb_full_st0_ctrl_seq;

  localparam int IN_LEN   = 6;
  localparam int NUM_ROWS = 12;
  localparam int PIPE_LAT = 5;
  localparam int PRE_LAT  = 3;
  localparam int NEVER    = 32'h3fff_ffff;

  typedef struct { int row; int beat; } beat_t;
  typedef struct { int t; int row; } evt_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_valid;
  logic [5:0] data_write_addr;
  logic [5:0] data_read_addr;
  logic [3:0] tap_address;
  logic       active_normal;
  logic       active_start_d;
  logic       active_pre;
  logic       active;
  logic [3:0] bias_wr_address;
  logic       read_finish;
  logic       stage_0_data_out_rdy;
  logic       busy;
  logic       overrun;

  int    testsRun = 0;
  int    testsFailed = 0;
  int    cyc = 0;
  int    lastWriteCyc = NEVER;
  int    finishCyc = 0;
  bit    finishSeen = 0;
  int    beatsSeen = 0;
  bit    strayNow = 0;
  bit    expOverrun = 0;
  beat_t expBeat[$];
  int    startQ[$];
  int    preQ[$];
  evt_t  actQ[$];
  evt_t  biasQ[$];

  full_st0_ctrl_seq dut (
    .clk(clk), .reset(reset), .data_valid(data_valid),
    .data_write_addr(data_write_addr), .data_read_addr(data_read_addr),
    .tap_address(tap_address), .active_normal(active_normal),
    .active_start_d(active_start_d), .active_pre(active_pre), .active(active),
    .bias_wr_address(bias_wr_address), .read_finish(read_finish),
    .stage_0_data_out_rdy(stage_0_data_out_rdy), .busy(busy), .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wraddr"}, data_write_addr, 0);
    checkOutput({tag, "_rdaddr"}, data_read_addr, 0);
    checkOutput({tag, "_tap"}, tap_address, 0);
    checkOutput({tag, "_normal"}, active_normal, 0);
    checkOutput({tag, "_start"}, active_start_d, 0);
    checkOutput({tag, "_pre"}, active_pre, 0);
    checkOutput({tag, "_active"}, active, 0);
    checkOutput({tag, "_bias"}, bias_wr_address, 0);
    checkOutput({tag, "_finish"}, read_finish, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
  endtask

  // Ready source: mostly high, with occasional 4-cycle low bursts.
  initial begin
    int lowLeft;
    lowLeft = 0;
    stage_0_data_out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (lowLeft == 0 && $urandom_range(0, 9) == 0) lowLeft = 4;
      stage_0_data_out_rdy = (lowLeft == 0);
      if (lowLeft > 0) lowLeft--;
    end
  end

  // Monitor: compares every strobe and marker against the scoreboard queues.
  always @(negedge clk) begin : monitor
    beat_t b;
    evt_t  e;
    int    t;
    bit    rdyEff;
`ifdef FULL_ST0_SEQ_STALL_EN
    rdyEff = stage_0_data_out_rdy;
`else
    rdyEff = 1'b1;
`endif
    while (startQ.size() > 0 && startQ[0] < cyc) begin
      t = startQ.pop_front();
      checkOutput("startMissed", 0, 1);
    end
    if (active_start_d) begin
      if (startQ.size() == 0) checkOutput("startUnexpected", 1, 0);
      else begin t = startQ.pop_front(); checkOutput("startTime", cyc, t); end
    end
    while (preQ.size() > 0 && preQ[0] < cyc) begin
      t = preQ.pop_front();
      checkOutput("preMissed", 0, 1);
    end
    if (active_pre) begin
      if (preQ.size() == 0) checkOutput("preUnexpected", 1, 0);
      else begin t = preQ.pop_front(); checkOutput("preTime", cyc, t); end
    end
    while (actQ.size() > 0 && actQ[0].t < cyc) begin
      e = actQ.pop_front();
      checkOutput("activeMissed", 0, 1);
    end
    if (active) begin
      if (actQ.size() == 0) checkOutput("activeUnexpected", 1, 0);
      else begin
        e = actQ.pop_front();
        checkOutput("activeTime", cyc, e.t);
        checkOutput("readFinish", read_finish, (e.row == NUM_ROWS - 1) ? 1 : 0);
        if (read_finish) begin finishSeen = 1; finishCyc = cyc; end
      end
    end else if (read_finish) begin
      checkOutput("finishWithoutActive", 1, 0);
    end
    while (biasQ.size() > 0 && biasQ[0].t <= cyc) begin
      e = biasQ.pop_front();
      if (e.t == cyc) checkOutput("biasAddr", bias_wr_address, e.row);
      else checkOutput("biasMissed", 0, 1);
    end
    checkOutput("overrun", overrun, expOverrun);
    if (data_valid && strayNow) expOverrun = 1;
    if (expBeat.size() > 0 && cyc > lastWriteCyc)
      checkOutput("issueTiming", active_normal, ((expBeat[0].beat != 0) || rdyEff) ? 1 : 0);
    if (active_normal) begin
      if (expBeat.size() == 0) checkOutput("beatUnexpected", 1, 0);
      else begin
        b = expBeat.pop_front();
        checkOutput("readAddr", data_read_addr, b.beat);
        checkOutput("tapAddr", tap_address, b.row);
        biasQ.push_back('{t: cyc + PIPE_LAT - 1, row: b.row});
        if (b.beat == 0) startQ.push_back(cyc + 1);
        if (b.beat == IN_LEN - 1) begin
          preQ.push_back(cyc + PRE_LAT);
          actQ.push_back('{t: cyc + PIPE_LAT, row: b.row});
        end
        beatsSeen++;
      end
    end
  end

  // One frame: gap idle cycles, six writes with random spacing, then either
  // run to completion (with optional stray writes) or abort with reset in row 7.
  task automatic applyStimulus(input int gap, input bit doStray, input bit doAbort);
    bit done;
    int n;
    repeat (gap) begin @(posedge clk); #1; data_valid = 1'b0; strayNow = 0; end
    for (int k = 0; k < IN_LEN; k++) begin
      @(posedge clk);
      #1;
      data_valid = 1'b1;
      strayNow = 0;
      if (k == IN_LEN - 1) begin
        lastWriteCyc = cyc;
        finishSeen = 0;
        beatsSeen = 0;
        for (int r = 0; r < NUM_ROWS; r++)
          for (int bt = 0; bt < IN_LEN; bt++)
            expBeat.push_back('{row: r, beat: bt});
      end
      @(negedge clk);
      checkOutput("writeAddr", data_write_addr, k);
      if (k == 0) checkOutput("busyInLoad", busy, 0);
      if (k < IN_LEN - 1) begin
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge clk); #1; data_valid = 1'b0; end
      end
    end
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk);
      #1;
      strayNow = doStray && (cyc > lastWriteCyc) && (cyc < lastWriteCyc + 60) &&
                 ($urandom_range(0, 7) == 0);
      data_valid = strayNow;
      @(negedge clk);
      if (cyc == lastWriteCyc + 1) checkOutput("busyRise", busy, 1);
      if (doAbort) begin
        if (beatsSeen >= 7 * IN_LEN + 2) done = 1;
      end else if (finishSeen && cyc == finishCyc + 2) begin
        checkOutput("busyInDone", busy, 1);
        done = 1;
      end
    end
    if (!done) checkOutput("frameTimeout", 0, 1);
    if (doAbort) begin
      @(posedge clk);
      #3;
      reset = 1'b0;
      expBeat.delete(); startQ.delete(); preQ.delete(); actQ.delete(); biasQ.delete();
      expOverrun = 0;
      lastWriteCyc = NEVER;
      #1;
      checkResetState("midReset");
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        checkOutput("postResetActive", active, 0);
        checkOutput("postResetFinish", read_finish, 0);
        checkOutput("postResetBusy", busy, 0);
        checkOutput("postResetWrAddr", data_write_addr, 0);
      end
    end else begin
      checkOutput("beatsLeft", expBeat.size(), 0);
      checkOutput("activeLeft", actQ.size(), 0);
      checkOutput("beatCount", beatsSeen, NUM_ROWS * IN_LEN);
    end
  endtask

  initial begin
    reset = 1'b0;
    data_valid = 1'b0;
    #2;
    checkResetState("initReset");
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(2, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(3, 0, 0);
    applyStimulus(0, 0, 0);
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/full_st0_ctrl_seq.md
Name: full_st0_ctrl_seq

Overview:
- Sequencer immediately upstream of the stage-0 output controller in the fully-connected layer.
- Counts input-vector writes into the data memory. Once a full vector is present, it walks every tap row and every data address, and produces the read strobes and addresses plus the pipeline-aligned valid, first and finish timing that the output controller consumes.
- Owns frame-level sequencing for stage 0; the output controller stays purely combinational/delay-based.

Parameters:
- IN_LEN, 6, data words per input vector; one inner-loop beat per word.
- NUM_ROWS, 12, tap rows (output neurons) per frame; tap_address range 0..NUM_ROWS-1.
- PIPE_LAT, 5, cycles from a read beat to the datapath result at the stage output.
- PRE_LAT, 3, cycles from a read beat to the pre-activation result.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- data_valid  in  1  input word written to data memory this cycle
- data_write_addr  out  6  write address for the incoming word
- data_read_addr  out  6  data memory read address
- tap_address  out  4  tap/bias memory row address
- active_normal  out  1  read strobe for data/tap/bias memories
- active_start_d  out  1  first-beat-of-row marker, delayed 1 cycle (memory latency)
- active_pre  out  1  pre-activation result valid
- active  out  1  final stage output valid
- bias_wr_address  out  4  row address aligned to the bias write-back
- read_finish  out  1  one-cycle pulse when the last row's result leaves
- stage_0_data_out_rdy  in  1  downstream ready (used only with the optional feature)
- busy  out  1  frame in progress, covering LOAD exit through DONE
- overrun  out  1  sticky: data_valid seen while not in LOAD

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset is asynchronous: asserting it mid-frame aborts immediately, clears every delay line, and raises no read_finish.
- IDLE → LOAD immediately; LOAD is the default input-collecting state.
- LOAD:
  - Each data_valid writes at data_write_addr, which then increments.
  - When the IN_LEN-th write lands (wcnt == IN_LEN-1 with data_valid), go to RUN next cycle and reset wcnt to 0.
- RUN:
  - active_normal = 1 every beat.
  - data_read_addr = beat index 0..IN_LEN-1; tap_address = row.
  - Beat wraps at IN_LEN-1 and increments row.
  - After beat IN_LEN-1 of row NUM_ROWS-1, go to DRAIN.
- DRAIN: active_normal = 0. Wait until the valid shift register is empty, then go to DONE.
- DONE: one cycle, then LOAD.
- Delay lines:
  - active_start_d = (beat == 0 & RUN) delayed 1.
  - Last-beat marker L = RUN & beat == IN_LEN-1.
  - active_pre = L delayed PRE_LAT.
  - active = L delayed PIPE_LAT.
  - bias_wr_address = tap_address delayed PIPE_LAT-1 (aligned with bias write-back).
- read_finish pulses the same cycle as the last row's active.
- data_valid outside LOAD: ignored and sets overrun; overrun clears only on reset.
- Simultaneous final write and state exit: the write is counted and the transition happens. No gap is required between a frame's DONE and the next LOAD write.
- Widths: beat counter ceil(log2(IN_LEN)), row counter 4 bits. No arithmetic wraps beyond parameter bounds; counters compare-and-clear, never roll over.

Optional Feature:
- Macro FULL_ST0_SEQ_STALL_EN.
- Defined:
  - In RUN, at beat 0 of a row, if stage_0_data_out_rdy = 0 the sequencer holds: active_normal = 0, beat/row frozen, no marker inserted.
  - A row already started always completes.
  - Delay lines keep shifting, so in-flight results still drain.
- Undefined: stage_0_data_out_rdy is ignored and rows issue back-to-back.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN, DRAIN, DONE) as a typedef; default IN_LEN/NUM_ROWS/PIPE_LAT constants shared with the output controller.
- One sub-module: full_st0_vld_delay, a parameterised-depth 1-bit shift register with async active-low clear. It is instantiated for active_start_d, active_pre and active; a width-4 variant carries bias_wr_address.

Test Plan:
- Load: 6 data_valid pulses → data_write_addr 0..5; RUN starts the cycle after the 6th; busy rises.
- Frame: full frame with defaults → 72 active_normal beats; tap_address 0..11, each held 6 cycles; 12 active pulses, the first 5 cycles after the first row's beat 5; read_finish coincides with the 12th active.
- Overrun: data_valid during RUN → overrun = 1 and stays 1; beat sequence is unaffected; next LOAD still starts at write address 0.
- Reset mid-frame: reset low during row 7 → all outputs 0 asynchronously; after release the sequencer is in LOAD with no stray active or read_finish.
- Stall (FULL_ST0_SEQ_STALL_EN): rdy low for 4 cycles at the start of row 3 → 4-cycle gap in active_normal; row 2's active still fires; total active count stays 12.
- Back-to-back: second frame's 6 writes begin the cycle after DONE → second frame runs with an identical 72-beat pattern.
